// File: rtl/serial_frame_rx.sv
// -----------------------------------------------------------------------------
// serial_frame_rx
//   Receives start-bit framed serial words (MSB first, idle level 1) sampled
//   on bit_valid strobes, and presents each completed word through a single
//   holding register with a valid/ready handshake.
//
//   Frame: start(0), WIDTH data bits MSB first, [even parity bit], stop(1).
//
// Optional feature:
//   SERIAL_FRAME_RX_PARITY_CHECK_EN - when defined, one even-parity bit is
//   expected between the data bits and the stop bit. A mismatching frame is
//   discarded and flagged on parity_err after its stop bit is sampled. When
//   undefined, parity_err is constantly 0.
//
// Ports:
//   clk        in   rising-edge clock
//   rst        in   synchronous active-high reset
//   bit_valid  in   serial_in is sampled only when 1
//   serial_in  in   serial bit stream
//   out_ready  in   consumer accepts out_data this cycle
//   out_data   out  last received word (WIDTH bits)
//   out_valid  out  out_data holds an unconsumed word
//   frame_err  out  one-cycle pulse: stop bit sampled as 0
//   overrun    out  one-cycle pulse: completed word dropped, holding reg full
//   parity_err out  one-cycle pulse: parity mismatch
// -----------------------------------------------------------------------------
module serial_frame_rx #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             bit_valid,
  input  logic             serial_in,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  output logic             frame_err,
  output logic             overrun,
  output logic             parity_err
);

  // Counter must be able to hold WIDTH itself (value after the last bit).
  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DATA   = 2'd1,
`ifdef SERIAL_FRAME_RX_PARITY_CHECK_EN
    S_PARITY = 2'd2,
`endif
    S_STOP   = 2'd3
  } state_t;

`ifdef SERIAL_FRAME_RX_PARITY_CHECK_EN
  // Even parity: data ones plus parity bit must be even; returns 1 on mismatch.
  function automatic logic parity_mismatch(input logic [WIDTH-1:0] data,
                                           input logic            pbit);
    return (^data) ^ pbit;
  endfunction
`endif

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_shift;
  logic [WIDTH-1:0] r_out_data;
  logic             r_out_valid;
  logic             r_frame_err;
  logic             r_overrun;
`ifdef SERIAL_FRAME_RX_PARITY_CHECK_EN
  logic             r_par_bad;
  logic             r_parity_err;
`endif

  logic w_stop_ok;
  logic w_deliver;
  logic w_take;

  // A good stop bit completes the frame; a parity-failed frame is not delivered.
  assign w_stop_ok = (r_state == S_STOP) && bit_valid && serial_in;
`ifdef SERIAL_FRAME_RX_PARITY_CHECK_EN
  assign w_deliver = w_stop_ok && !r_par_bad;
`else
  assign w_deliver = w_stop_ok;
`endif
  assign w_take = r_out_valid && out_ready;

  // Frame FSM, shift register and holding register with registered pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= {CNT_W{1'b0}};
      r_shift     <= {WIDTH{1'b0}};
      r_out_data  <= {WIDTH{1'b0}};
      r_out_valid <= 1'b0;
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;
`ifdef SERIAL_FRAME_RX_PARITY_CHECK_EN
      r_par_bad    <= 1'b0;
      r_parity_err <= 1'b0;
`endif
    end else begin
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;
`ifdef SERIAL_FRAME_RX_PARITY_CHECK_EN
      r_parity_err <= 1'b0;
`endif

      // Holding register: a completion coinciding with a handshake replaces
      // the consumed word; only a full, unconsumed register drops the new one.
      if (w_deliver) begin
        if (r_out_valid && !out_ready) begin
          r_overrun <= 1'b1;
        end else begin
          r_out_data  <= r_shift;
          r_out_valid <= 1'b1;
        end
      end else if (w_take) begin
        r_out_valid <= 1'b0;
      end

      case (r_state)
        S_IDLE: begin
          if (bit_valid && !serial_in) begin
            r_state <= S_DATA;
            r_cnt   <= {CNT_W{1'b0}};
`ifdef SERIAL_FRAME_RX_PARITY_CHECK_EN
            r_par_bad <= 1'b0;
`endif
          end
        end
        S_DATA: begin
          if (bit_valid) begin
            r_shift <= {r_shift[WIDTH-2:0], serial_in};
            r_cnt   <= r_cnt + CNT_W'(1);
            if (r_cnt == LAST_BIT) begin
`ifdef SERIAL_FRAME_RX_PARITY_CHECK_EN
              r_state <= S_PARITY;
`else
              r_state <= S_STOP;
`endif
            end
          end
        end
`ifdef SERIAL_FRAME_RX_PARITY_CHECK_EN
        S_PARITY: begin
          if (bit_valid) begin
            r_par_bad <= parity_mismatch(r_shift, serial_in);
            r_state   <= S_STOP;
          end
        end
`endif
        S_STOP: begin
          if (bit_valid) begin
            // A bad stop bit is reported as frame_err only, even when the
            // parity was also wrong.
            if (serial_in) begin
`ifdef SERIAL_FRAME_RX_PARITY_CHECK_EN
              if (r_par_bad) begin
                r_parity_err <= 1'b1;
              end
`endif
            end else begin
              r_frame_err <= 1'b1;
            end
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign out_data  = r_out_data;
  assign out_valid = r_out_valid;
  assign frame_err = r_frame_err;
  assign overrun   = r_overrun;
`ifdef SERIAL_FRAME_RX_PARITY_CHECK_EN
  assign parity_err = r_parity_err;
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_serial_frame_rx.sv
// -----------------------------------------------------------------------------
// tb_serial_frame_rx
//   Frame-level reference model plus scoreboard for serial_frame_rx.
//   The stimulus side builds whole frames from bit lists and predicts, per
//   frame, whether a word is delivered or which error pulse is due; a
//   separate monitor pops the predictions as the DUT presents them.
// -----------------------------------------------------------------------------
module tb_serial_frame_rx;

  localparam int WIDTH = 8;

`ifdef SERIAL_FRAME_RX_PARITY_CHECK_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  // event codes for the pulse queue
  localparam int EV_FE  = 1;
  localparam int EV_OVR = 2;
  localparam int EV_PE  = 3;

  logic             clk = 1'b0;
  logic             rst;
  logic             bit_valid;
  logic             serial_in;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             frame_err;
  logic             overrun;
  logic             parity_err;

  int errors = 0;
  int checks = 0;

  logic [WIDTH-1:0] word_q[$];
  int               ev_q[$];
  bit               m_full = 1'b0;
  int               rdy_pct = 0;

  serial_frame_rx #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .bit_valid  (bit_valid),
    .serial_in  (serial_in),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .frame_err  (frame_err),
    .overrun    (overrun),
    .parity_err (parity_err)
  );

  always #5 clk = ~clk;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  function automatic void chk_ev(int code);
    if (ev_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL pulse_unexpected: got pulse code %0d expected none", code);
    end else begin
      check("pulse_kind", ev_q.pop_front(), code);
    end
  endfunction

  // Monitor: inputs are stable at the falling edge, so valid&ready here is
  // exactly the handshake the DUT takes at the next rising edge.
  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid && out_ready) begin
        if (word_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL word_unexpected: got %0h expected none", out_data);
        end else begin
          check("word", out_data, word_q.pop_front());
        end
      end
      if (frame_err)  chk_ev(EV_FE);
      if (overrun)    chk_ev(EV_OVR);
      if (parity_err) chk_ev(EV_PE);
    end
  end

  // One clock of stimulus. ev: 0 none, 1 good stop, 2 bad stop, 3 parity fail.
  // rdy < 0 selects a random out_ready drawn with rdy_pct.
  task automatic tick(input logic bv, input logic sin, input int ev,
                      input int rdy, input logic [WIDTH-1:0] w);
    rst       = 1'b0;
    bit_valid = bv;
    serial_in = sin;
    if (rdy < 0) out_ready = ($urandom_range(99, 0) < rdy_pct);
    else         out_ready = rdy[0];
    if (ev == 1) begin
      if (m_full && !out_ready) begin
        ev_q.push_back(EV_OVR);
      end else begin
        word_q.push_back(w);
        m_full = 1'b1;
      end
    end else begin
      if (ev == 2) ev_q.push_back(EV_FE);
      if (ev == 3) ev_q.push_back(EV_PE);
      if (m_full && out_ready) m_full = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic gaps(input int gmin, input int gmax);
    int n;
    n = $urandom_range(gmax, gmin);
    for (int i = 0; i < n; i++) tick(1'b0, 1'($urandom), 0, -1, '0);
  endtask

  task automatic idle(input int n, input int rdy);
    for (int i = 0; i < n; i++) tick(1'b0, 1'b1, 0, rdy, '0);
  endtask

  task automatic send_frame(input logic [WIDTH-1:0] w, input bit stop,
                            input bit pflip, input int gmin, input int gmax,
                            input int stop_rdy);
    int ev;
    tick(1'b1, 1'b0, 0, -1, w);
    gaps(gmin, gmax);
    for (int i = WIDTH - 1; i >= 0; i--) begin
      tick(1'b1, w[i], 0, -1, w);
      gaps(gmin, gmax);
    end
    if (PAR_EN) begin
      tick(1'b1, (^w) ^ pflip, 0, -1, w);
      gaps(gmin, gmax);
    end
    if (!stop)              ev = 2;
    else if (PAR_EN && pflip) ev = 3;
    else                    ev = 1;
    tick(1'b1, stop, ev, stop_rdy, w);
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    bit_valid = 1'($urandom);
    serial_in = 1'b0;
    out_ready = 1'b1;
    if (m_full) void'(word_q.pop_back());
    m_full = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic check_all_zero(string tag);
    check({tag, "_valid"}, out_valid, 0);
    check({tag, "_data"}, out_data, 0);
    check({tag, "_ferr"}, frame_err, 0);
    check({tag, "_ovr"}, overrun, 0);
    check({tag, "_perr"}, parity_err, 0);
  endtask

  initial begin
    rst = 1'b1; bit_valid = 1'b0; serial_in = 1'b1; out_ready = 1'b0;
    do_reset();
    do_reset();
    check_all_zero("reset");

    // A5 with bit_valid every cycle; word visible right after the stop edge
    rdy_pct = 0;
    send_frame(8'hA5, 1'b1, 1'b0, 0, 0, 0);
    check("a5_valid", out_valid, 1);
    check("a5_data", out_data, 8'hA5);
    idle(3, 1);

    // 3C with bit_valid every 4th cycle; random serial_in while not valid
    send_frame(8'h3C, 1'b1, 1'b0, 3, 3, 0);
    check("3c_valid", out_valid, 1);
    check("3c_data", out_data, 8'h3C);
    idle(3, 1);

    // FF with stop bit 0: single frame_err pulse, no word
    send_frame(8'hFF, 1'b0, 1'b0, 0, 0, 0);
    check("ff_ferr", frame_err, 1);
    check("ff_valid", out_valid, 0);
    idle(1, 0);
    check("ff_ferr_end", frame_err, 0);
    check("ff_valid_end", out_valid, 0);

    // 11 then 22 with out_ready low: 22 dropped with overrun
    send_frame(8'h11, 1'b1, 1'b0, 0, 0, 0);
    send_frame(8'h22, 1'b1, 1'b0, 0, 0, 0);
    check("ovr_pulse", overrun, 1);
    check("ovr_keep", out_data, 8'h11);
    idle(1, 0);
    check("ovr_end", overrun, 0);
    // 22 again, consumer accepting 11 on the completion cycle
    send_frame(8'h22, 1'b1, 1'b0, 0, 0, 1);
    check("hs_ovr", overrun, 0);
    check("hs_valid", out_valid, 1);
    check("hs_data", out_data, 8'h22);
    idle(3, 1);

    // reset after the 4th data bit aborts the frame
    tick(1'b1, 1'b0, 0, 0, '0);
    for (int i = 7; i >= 4; i--) tick(1'b1, 1'(8'h9A >> i), 0, 0, '0);
    do_reset();
    check_all_zero("abort");
    idle(2, 0);
    check("abort_quiet", out_valid, 0);
    send_frame(8'h81, 1'b1, 1'b0, 0, 1, 0);
    check("81_valid", out_valid, 1);
    check("81_data", out_data, 8'h81);
    idle(3, 1);

    if (PAR_EN) begin
      send_frame(8'h07, 1'b1, 1'b1, 0, 0, 0);
      check("par_bad_perr", parity_err, 1);
      check("par_bad_valid", out_valid, 0);
      idle(1, 0);
      check("par_bad_end", parity_err, 0);
      send_frame(8'h07, 1'b1, 1'b0, 0, 0, 0);
      check("par_ok_valid", out_valid, 1);
      check("par_ok_data", out_data, 8'h07);
      check("par_ok_perr", parity_err, 0);
      idle(3, 1);
    end

    // randomized frames, errors and back-pressure
    rdy_pct = 50;
    for (int f = 0; f < 150; f++) begin
      send_frame(WIDTH'($urandom), ($urandom_range(9, 0) != 0),
                 ($urandom_range(9, 0) == 0), 0, 2, -1);
      for (int k = $urandom_range(3, 0); k > 0; k--) begin
        logic bv;
        bv = 1'($urandom);
        tick(bv, bv ? 1'b1 : 1'($urandom), 0, -1, '0);
      end
    end

    idle(10, 1);
    check("drain_words", word_q.size(), 0);
    check("drain_pulses", ev_q.size(), 0);
    check("drain_valid", out_valid, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/serial_frame_rx.md
SERIAL_FRAME_RX -- requirements
Module: serial_frame_rx

Interface
REQ-001 SHALL have parameter WIDTH, default 8: number of data bits per frame (legal values 2..32).
REQ-002 SHALL have port clk  input  1  rising-edge clock for all state.
REQ-003 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port bit_valid  input  1  serial_in is sampled only on cycles where this is 1.
REQ-005 SHALL have port serial_in  input  1  serial bit stream, MSB-first data, idle level 1.
REQ-006 SHALL have port out_ready  input  1  consumer accepts out_data this cycle.
REQ-007 SHALL have port out_data  output  WIDTH  last received word.
REQ-008 SHALL have port out_valid  output  1  out_data holds an unconsumed word.
REQ-009 SHALL have port frame_err  output  1  one-cycle pulse: stop bit sampled as 0.
REQ-010 SHALL have port overrun  output  1  one-cycle pulse: completed word dropped because the holding register was full.
REQ-011 SHALL have port parity_err  output  1  one-cycle pulse: parity mismatch (tied 0 without PARITY_CHECK_EN).

Function
REQ-012 SHALL implement states IDLE, DATA, PARITY, STOP; PARITY exists only with PARITY_CHECK_EN.
REQ-013 SHALL leave IDLE only on bit_valid=1 with serial_in=0 (start bit); entering DATA clears the bit counter to 0.
REQ-014 SHALL, in DATA, on each bit_valid, shift serial_in into the LSB of an internal WIDTH-bit shift register (left shift) and increment the counter.
REQ-015 SHALL leave DATA after exactly WIDTH sampled bits, entering PARITY if enabled, otherwise STOP.
REQ-016 SHALL ignore cycles with bit_valid=0 in every state (state, counter and shift register hold).
REQ-017 SHALL, in STOP, on bit_valid with serial_in=1, complete the frame and return to IDLE.
REQ-018 SHALL, in STOP, on bit_valid with serial_in=0, pulse frame_err the next cycle, discard the word and return to IDLE.
REQ-019 SHALL, on completion with out_valid=0, load out_data and set out_valid on the next clock edge (latency 1 cycle from the stop-bit sample).
REQ-020 SHALL hold out_valid and out_data stable until a cycle with out_valid=1 and out_ready=1, after which out_valid clears.
REQ-021 SHALL, on completion while out_valid=1 and out_ready=0, keep the old out_data, drop the new word and pulse overrun.
REQ-022 SHALL, on completion in the same cycle as an out_valid/out_ready handshake, load the new word and keep out_valid=1 with no overrun.
REQ-023 SHALL reject a frame with both a parity error and a stop error by pulsing frame_err only.

Reset
REQ-024 SHALL, while rst=1 at a clock edge, set state IDLE, counter 0, shift register 0, out_data 0, out_valid 0, frame_err 0, overrun 0, parity_err 0.
REQ-025 SHALL abort any in-progress frame on rst, with no output pulse and no word delivered.
REQ-026 SHALL give rst priority over bit_valid and out_ready in the same cycle.

Configuration
REQ-027 SHALL, with macro SERIAL_FRAME_RX_PARITY_CHECK_EN defined, expect one even-parity bit after the data bits; on mismatch it SHALL pulse parity_err, discard the word, and still sample the stop bit before returning to IDLE.
REQ-028 SHALL, without SERIAL_FRAME_RX_PARITY_CHECK_EN, expect the stop bit directly after the data bits and drive parity_err constantly 0.

Verification
REQ-029 SHALL cover: WIDTH=8, bit_valid every cycle, bits 0,1,0,1,0,0,1,0,1,1 -> out_valid=1 with out_data=8'hA5 one cycle after the stop bit.
REQ-030 SHALL cover: frame for 8'h3C with bit_valid=1 every 4th cycle -> out_data=8'h3C; state holds on all idle cycles.
REQ-031 SHALL cover: stop bit 0 on frame for 8'hFF -> frame_err is a single-cycle pulse, out_valid stays 0.
REQ-032 SHALL cover: two frames 8'h11 then 8'h22 with out_ready=0 -> out_data=8'h11 and overrun pulses once; repeat with out_ready=1 on the completion cycle -> out_data=8'h22, no overrun.
REQ-033 SHALL cover: rst=1 after the 4th data bit -> all outputs 0, and the next valid frame for 8'h81 is received correctly.
REQ-034 SHALL cover, with PARITY_CHECK_EN: 8'h07 with parity bit 0 (wrong) -> parity_err pulses, no word; with parity bit 1 -> out_data=8'h07.
